// File: rtl/intra_pred_scheduler_if.sv
// intra_pred_scheduler_if
//
// Purpose: bundles the control and status signals of the angular
// intra-prediction scheduler. Clock and reset are not part of the bundle.
//
// Signals:
//   start, abort, ref_ack, ready_in  - driven by the controlling side (master)
//   ref_req, busy                    - block-level status from the scheduler
//   en1, en2                         - stage-1 / stage-2 pipeline enables
//   row_valid, out_mode, out_row     - stage-2 output row valid and its tag
//   mode_done, all_done              - completion pulses
//
// Modports:
//   master - controller / environment side
//   slave  - the scheduler itself
interface intra_pred_scheduler_if #(
    parameter int BLK_LOG2 = 3
);
    logic                start;
    logic                abort;
    logic                ref_ack;
    logic                ready_in;
    logic                ref_req;
    logic                busy;
    logic                en1;
    logic                en2;
    logic                row_valid;
    logic [5:0]          out_mode;
    logic [BLK_LOG2-1:0] out_row;
    logic                mode_done;
    logic                all_done;

    modport master (
        output start, abort, ref_ack, ready_in,
        input  ref_req, busy, en1, en2, row_valid, out_mode, out_row,
               mode_done, all_done
    );

    modport slave (
        input  start, abort, ref_ack, ready_in,
        output ref_req, busy, en1, en2, row_valid, out_mode, out_row,
               mode_done, all_done
    );
endinterface

// File: rtl/intra_pred_scheduler.sv
// intra_pred_scheduler
//
// Purpose: sequences one prediction block through every angular mode, row by
// row. After a single reference-sample load it issues one (mode,row) pair per
// cycle into a two-stage prediction pipeline (en1 = index/weight stage,
// en2 = interpolation stage). A mode/row tag follows each row so the cost
// unit can attribute the stage-2 output. ready_in low freezes everything.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   bus (slave)  - start/abort/ref_ack/ready_in in; ref_req, busy, en1, en2,
//                  row_valid, out_mode, out_row, mode_done, all_done out
//
// Parameters:
//   BLK_LOG2    - log2 of block size N (N rows per mode)
//   MODE_FIRST  - first angular mode issued
//   MODE_LAST   - last angular mode issued
//
// Build option:
//   INTRA_SCHED_PLANAR_DC_EN - when defined, modes 0 (planar) and 1 (DC)
//   are issued before MODE_FIRST..MODE_LAST.
module intra_pred_scheduler #(
    parameter int BLK_LOG2   = 3,
    parameter int MODE_FIRST = 2,
    parameter int MODE_LAST  = 34
) (
    input logic                   clk,
    input logic                   rst_n,
    intra_pred_scheduler_if.slave bus
);

    localparam logic [BLK_LOG2-1:0] ROW_LAST     = '1;
    localparam logic [5:0]          MODE_FIRST_L = 6'(MODE_FIRST);
    localparam logic [5:0]          MODE_LAST_L  = 6'(MODE_LAST);
`ifdef INTRA_SCHED_PLANAR_DC_EN
    localparam logic [5:0]          MODE_START   = 6'd0;
`else
    localparam logic [5:0]          MODE_START   = MODE_FIRST_L;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

    state_t              state;
    logic [5:0]          mode_cnt;
    logic [BLK_LOG2-1:0] row_cnt;
    logic                s1, s2;
    logic [5:0]          s1_mode, s2_mode;
    logic [BLK_LOG2-1:0] s1_row, s2_row;
    logic                ref_req_q, busy_q, mode_done_q, all_done_q;

    logic                adv, issue, xfer, last_issue, last_xfer, pipe_on;
    logic [5:0]          mode_next;

    // abort outranks ready_in, so an aborting cycle neither advances nor
    // counts as a transfer; done pulses are therefore suppressed as well.
    always_comb begin
        pipe_on    = (state == RUN) || (state == FLUSH);
        adv        = bus.ready_in & ~bus.abort;
        issue      = (state == RUN) & adv;
        xfer       = s2 & bus.ready_in & ~bus.abort;
        last_issue = issue && (mode_cnt == MODE_LAST_L) && (row_cnt == ROW_LAST);
        last_xfer  = (state == FLUSH) && xfer &&
                     (s2_mode == MODE_LAST_L) && (s2_row == ROW_LAST);
        mode_next  = mode_cnt + 6'd1;
`ifdef INTRA_SCHED_PLANAR_DC_EN
        // DC (mode 1) is followed directly by the first angular mode
        if (mode_cnt == 6'd1)
            mode_next = MODE_FIRST_L;
`endif
    end

    assign bus.en1       = issue;
    assign bus.en2       = pipe_on & adv & s1;
    assign bus.row_valid = s2;
    assign bus.out_mode  = s2_mode;
    assign bus.out_row   = s2_row;
    assign bus.ref_req   = ref_req_q;
    assign bus.busy      = busy_q;
    assign bus.mode_done = mode_done_q;
    assign bus.all_done  = all_done_q;

    // Control FSM, row/mode counters and the two-stage valid/tag pipeline.
    // Done pulses are registered and appear the cycle after the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_cnt    <= '0;
            row_cnt     <= '0;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s1_mode     <= '0;
            s2_mode     <= '0;
            s1_row      <= '0;
            s2_row      <= '0;
            ref_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            mode_done_q <= 1'b0;
            all_done_q  <= 1'b0;
        end else begin
            mode_done_q <= 1'b0;
            all_done_q  <= 1'b0;
            if (busy_q && bus.abort) begin
                state     <= IDLE;
                busy_q    <= 1'b0;
                ref_req_q <= 1'b0;
                s1        <= 1'b0;
                s2        <= 1'b0;
                s1_mode   <= '0;
                s2_mode   <= '0;
                s1_row    <= '0;
                s2_row    <= '0;
            end else begin
                if (xfer && (s2_row == ROW_LAST))
                    mode_done_q <= 1'b1;
                if (pipe_on && adv) begin
                    s1      <= issue;
                    s1_mode <= mode_cnt;
                    s1_row  <= row_cnt;
                    s2      <= s1;
                    s2_mode <= s1_mode;
                    s2_row  <= s1_row;
                end
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state     <= LOAD;
                            busy_q    <= 1'b1;
                            ref_req_q <= 1'b1;
                            mode_cnt  <= MODE_START;
                            row_cnt   <= '0;
                        end
                    end
                    LOAD: begin
                        if (bus.ref_ack) begin
                            state     <= RUN;
                            ref_req_q <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (last_issue) begin
                            state <= FLUSH;
                        end else if (issue) begin
                            row_cnt <= row_cnt + 1'b1;
                            if (row_cnt == ROW_LAST)
                                mode_cnt <= mode_next;
                        end
                    end
                    FLUSH: begin
                        if (last_xfer) begin
                            state      <= IDLE;
                            busy_q     <= 1'b0;
                            all_done_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_intra_pred_scheduler.sv
// tb_intra_pred_scheduler
//
// Purpose: directed, self-checking bench for intra_pred_scheduler. Expected
// (mode,row) tags are queued when a block is started and popped on every
// observed transfer; done pulses are predicted from the popped tags.
module tb_intra_pred_scheduler;

    localparam int N = 8;
`ifdef INTRA_SCHED_PLANAR_DC_EN
    localparam int TOTAL     = 280;
    localparam int MODES     = 35;
    localparam int ABORT_MD  = 20;
    localparam int FIRST_TAG = {6'd0, 3'd0};
`else
    localparam int TOTAL     = 264;
    localparam int MODES     = 33;
    localparam int ABORT_MD  = 18;
    localparam int FIRST_TAG = {6'd2, 3'd0};
`endif

    logic clk;
    logic rst_n;

    intra_pred_scheduler_if #(.BLK_LOG2(3)) intf ();

    intra_pred_scheduler #(
        .BLK_LOG2  (3),
        .MODE_FIRST(2),
        .MODE_LAST (34)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] last_tag = '0;
    logic       prev_md_exp = 1'b0;
    logic       prev_ad_exp = 1'b0;
    logic       xfer_now = 1'b0;
    logic       seen_all = 1'b0;
    int         cycle = 0;
    int         xfer_count = 0;
    int         md_count = 0;
    int         ad_count = 0;
    int         first_cycle = 0;
    int         last_cycle = 0;
    bit         aborted;

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: pops the expected tag on each transfer and predicts the
    // registered done pulses for the following cycle.
    task automatic scoreboardCheck();
        logic [8:0] got;
        logic [8:0] exp;
        cycle++;
        checkOutput("mode_done", 32'(intf.mode_done), 32'(prev_md_exp));
        checkOutput("all_done", 32'(intf.all_done), 32'(prev_ad_exp));
        if (intf.mode_done === 1'b1) md_count++;
        if (intf.all_done === 1'b1) begin
            ad_count++;
            seen_all = 1'b1;
        end
        prev_md_exp = 1'b0;
        prev_ad_exp = 1'b0;
        xfer_now    = 1'b0;
        if (intf.row_valid === 1'b1 && intf.ready_in === 1'b1) begin
            xfer_now = 1'b1;
            got = {intf.out_mode, intf.out_row};
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_row", 32'(got), 32'h3ff);
            end else begin
                exp = exp_q.pop_front();
                checkOutput("row_tag", 32'(got), 32'(exp));
                last_tag    = exp;
                prev_md_exp = (exp[2:0] == 3'(N - 1));
                prev_ad_exp = (exp == {6'd34, 3'd7});
                if (xfer_count == 0) first_cycle = cycle;
                last_cycle = cycle;
                xfer_count++;
            end
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then sample at
    // the falling edge.
    task automatic applyStimulus(input logic st, input logic ab,
                                 input logic ack, input logic rdy);
        @(posedge clk);
        #1;
        intf.start    = st;
        intf.abort    = ab;
        intf.ref_ack  = ack;
        intf.ready_in = rdy;
        @(negedge clk);
        scoreboardCheck();
    endtask

    task automatic pushSeq();
`ifdef INTRA_SCHED_PLANAR_DC_EN
        for (int m = 0; m < 2; m++)
            for (int r = 0; r < N; r++)
                exp_q.push_back({6'(m), 3'(r)});
`endif
        for (int m = 2; m <= 34; m++)
            for (int r = 0; r < N; r++)
                exp_q.push_back({6'(m), 3'(r)});
    endtask

    // start, ref_ack three cycles later, then two cycles of pipeline fill
    task automatic loadPhase(input logic poke);
        xfer_count = 0;
        md_count   = 0;
        ad_count   = 0;
        seen_all   = 1'b0;
        applyStimulus(1, 0, 0, 0);
        pushSeq();
        checkOutput("c0_busy", 32'(intf.busy), 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("c1_ref_req", 32'(intf.ref_req), 1);
        checkOutput("c1_busy", 32'(intf.busy), 1);
        applyStimulus(poke, 0, 0, 0);
        checkOutput("c2_ref_req", 32'(intf.ref_req), 1);
        checkOutput("c2_en1", 32'(intf.en1), 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("c3_ref_req", 32'(intf.ref_req), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("c4_ref_req", 32'(intf.ref_req), 0);
        checkOutput("c4_en1", 32'(intf.en1), 1);
        checkOutput("c4_en2", 32'(intf.en2), 0);
        checkOutput("c4_row_valid", 32'(intf.row_valid), 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("c5_en2", 32'(intf.en2), 1);
        checkOutput("c5_row_valid", 32'(intf.row_valid), 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("c6_row_valid", 32'(intf.row_valid), 1);
        checkOutput("c6_first_tag", 32'({intf.out_mode, intf.out_row}), 32'(FIRST_TAG));
    endtask

    // Streams with ready_in high until all_done, optionally stalling at
    // (10,3), aborting after (20,3), or pulsing start mid-run.
    task automatic runBlock(input bit do_stall, input bit do_abort,
                            input bit do_poke, output bit was_aborted);
        bit stalled;
        stalled     = 1'b0;
        was_aborted = 1'b0;
        for (int i = 0; i < 600 && !seen_all && !was_aborted; i++) begin
            if (do_stall && !stalled && xfer_now && last_tag == {6'd10, 3'd2}) begin
                stalled = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    applyStimulus(0, 0, 0, 0);
                    checkOutput("stall_en1", 32'(intf.en1), 0);
                    checkOutput("stall_en2", 32'(intf.en2), 0);
                    checkOutput("stall_valid", 32'(intf.row_valid), 1);
                    checkOutput("stall_mode", 32'(intf.out_mode), 10);
                    checkOutput("stall_row", 32'(intf.out_row), 3);
                end
            end else if (do_abort && xfer_now && last_tag == {6'd20, 3'd3}) begin
                applyStimulus(0, 1, 0, 0);
                applyStimulus(0, 0, 0, 0);
                checkOutput("abort_busy", 32'(intf.busy), 0);
                checkOutput("abort_row_valid", 32'(intf.row_valid), 0);
                checkOutput("abort_ref_req", 32'(intf.ref_req), 0);
                checkOutput("abort_en1", 32'(intf.en1), 0);
                exp_q.delete();
                was_aborted = 1'b1;
            end else begin
                applyStimulus(logic'(do_poke && i == 40), 0, 0, 1);
            end
        end
        if (!was_aborted)
            checkOutput("all_done_seen", 32'(seen_all), 1);
    endtask

    initial begin
        rst_n         = 1'b0;
        intf.start    = 1'b0;
        intf.abort    = 1'b0;
        intf.ref_ack  = 1'b0;
        intf.ready_in = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_ref_req", 32'(intf.ref_req), 0);
        checkOutput("rst_busy", 32'(intf.busy), 0);
        checkOutput("rst_en1", 32'(intf.en1), 0);
        checkOutput("rst_en2", 32'(intf.en2), 0);
        checkOutput("rst_row_valid", 32'(intf.row_valid), 0);
        checkOutput("rst_tag", 32'({intf.out_mode, intf.out_row}), 0);
        checkOutput("rst_done", 32'({intf.mode_done, intf.all_done}), 0);
        rst_n = 1'b1;

        // full block with a 5-cycle stall at (10,3)
        $display("[TB] block A: full run with stall");
        loadPhase(1'b0);
        runBlock(1'b1, 1'b0, 1'b0, aborted);
        checkOutput("A_busy_at_done", 32'(intf.busy), 0);
        checkOutput("A_xfers", 32'(xfer_count), 32'(TOTAL));
        checkOutput("A_span", 32'(last_cycle - first_cycle + 1), 32'(TOTAL + 5));
        checkOutput("A_mode_done", 32'(md_count), 32'(MODES));
        checkOutput("A_all_done", 32'(ad_count), 1);
        checkOutput("A_last_tag", 32'(last_tag), 32'({6'd34, 3'd7}));
        checkOutput("A_queue_empty", 32'(exp_q.size()), 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("A_idle_busy", 32'(intf.busy), 0);

        // abort at mode 20, start pulse ignored during LOAD
        $display("[TB] block B: abort at mode 20");
        loadPhase(1'b1);
        runBlock(1'b0, 1'b1, 1'b0, aborted);
        checkOutput("B_aborted", 32'(aborted), 1);
        checkOutput("B_mode_done", 32'(md_count), 32'(ABORT_MD));
        checkOutput("B_all_done", 32'(ad_count), 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("B_idle_busy", 32'(intf.busy), 0);

        // restart after abort, start pulse ignored during RUN
        $display("[TB] block C: restart after abort");
        loadPhase(1'b0);
        runBlock(1'b0, 1'b0, 1'b1, aborted);
        checkOutput("C_busy_at_done", 32'(intf.busy), 0);
        checkOutput("C_xfers", 32'(xfer_count), 32'(TOTAL));
        checkOutput("C_span", 32'(last_cycle - first_cycle + 1), 32'(TOTAL));
        checkOutput("C_mode_done", 32'(md_count), 32'(MODES));
        checkOutput("C_all_done", 32'(ad_count), 1);
        checkOutput("C_queue_empty", 32'(exp_q.size()), 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("C_idle_ref_req", 32'(intf.ref_req), 0);
        checkOutput("C_idle_busy", 32'(intf.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/intra_pred_scheduler.md
Name: intra_pred_scheduler

Overview:
Sequencer for the angular intra-prediction datapath: it drives one prediction block through every angular mode, row by row. It requests the reference-sample load once per block. It then issues rows into the two-stage prediction pipeline through en1 (stage 1, index/weight calc) and en2 (stage 2, interpolation). A per-row mode/row tag travels alongside the pipeline so the downstream cost unit (SAD/SATD) can attribute each output row. Downstream backpressure freezes the whole pipeline.

Parameters:
BLK_LOG2, 3, log2 of block size N (N = 1<<BLK_LOG2 rows per mode)
MODE_FIRST, 2, first angular mode issued
MODE_LAST, 34, last angular mode issued (must be >= MODE_FIRST)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous assert, active-low
start  in  1  1-cycle pulse; begin a block; ignored while busy=1
abort  in  1  synchronous abort; ignored while busy=0
ref_ack  in  1  reference samples loaded
ready_in  in  1  downstream accepts the current output row
ref_req  out  1  request reference-sample load
busy  out  1  high from accepted start until all_done or abort
en1  out  1  stage-1 enable
en2  out  1  stage-2 enable
row_valid  out  1  stage-2 output row valid
out_mode  out  6  mode tag of the output row
out_row  out  BLK_LOG2  row tag of the output row
mode_done  out  1  1-cycle pulse on transfer of row N-1 of any mode
all_done  out  1  1-cycle pulse on transfer of the final row of the block

Behaviour:
- Reset: state IDLE; every output 0; internal mode/row counters, stage valids s1/s2 and tags all 0.
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- States: IDLE, LOAD, RUN, FLUSH.
- IDLE: on start, go to LOAD; mode counter <= MODE_FIRST; row counter <= 0.
- LOAD: ref_req=1 and busy=1. On ref_ack, go to RUN next cycle; ref_req=0 from that cycle.
- RUN:
  - adv = ready_in. en1 = adv. en2 = adv & s1.
  - Each en1 cycle issues (mode counter, row counter) into stage 1, then increments the row counter.
  - Row wrap: at N-1 the row counter returns to 0 and the mode counter increments.
  - When the issued row is (MODE_LAST, N-1), go to FLUSH; no further en1.
- FLUSH:
  - en1=0; en2 = adv & s1.
  - Stay until the final row is transferred, then go to IDLE.
  - On leaving FLUSH: all_done=1 for 1 cycle and busy=0.
- Pipeline:
  - When adv=1: s1 <= issue; s2 <= s1; tags shift with the valids.
  - When adv=0: s1, s2 and tags hold.
  - row_valid = s2; out_mode/out_row = stage-2 tag.
  - Transfer occurs when row_valid & ready_in.
  - Latency: row issued by en1 at cycle t appears as row_valid at t+2 if ready_in stays high.
- Throughput: 1 row/cycle with ready_in=1; no bubble between modes, since reference samples are shared across modes.
- Stall: ready_in=0 forces en1=en2=0; counters, valids and tags hold; no row is lost or duplicated.
- Simultaneous events:
  - abort has priority over ready_in, ref_ack and start.
  - mode_done and all_done may both pulse in the same cycle (last row).
- Abort:
  - Next cycle: state IDLE, busy=0, ref_req=0, s1=s2=0, row_valid=0.
  - No mode_done/all_done pulse.
  - Counters are reinitialised by the next start.
- Reset mid-operation is equivalent to abort, applied asynchronously.
- Totals: (MODE_LAST-MODE_FIRST+1)*N transfers per block; 264 for defaults.

Optional Feature:
INTRA_SCHED_PLANAR_DC_EN:
- Defined: the mode sequence starts at 0 (planar), then 1 (DC), then continues MODE_FIRST..MODE_LAST. Defaults give 35*8 = 280 transfers.
- Undefined: the sequence is MODE_FIRST..MODE_LAST only.

Test Plan:
1. Reset with inputs at 0 -> all outputs 0; state IDLE; start still accepted on the first cycle after deassert.
2. start, ref_ack 3 cycles later, ready_in=1 -> first en1 one cycle after ref_ack; first row_valid 2 cycles later with out_mode=2, out_row=0; 264 transfers in 264 consecutive cycles; mode_done every 8th transfer; all_done with (34,7); then busy=0.
3. ready_in low for 5 cycles while out_mode=10, out_row=3 -> en1=en2=0; tags held at (10,3); sequence resumes with no gap or duplicate.
4. abort in RUN at mode 20 -> next cycle busy=0, row_valid=0; no done pulses; a new start raises ref_req and restarts at mode 2, row 0.
5. start pulses during LOAD and RUN -> ignored; transfer count unchanged at 264.
6. Build with INTRA_SCHED_PLANAR_DC_EN -> modes 0, 1, 2..34; 280 transfers; first tag (0,0); last tag (34,7).
